encoder4: RTL
=============

ENCODER4 -- requirements
Module: encoder4

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  program-shift enable.
REQ-005 SHALL have port prgm  input  1  serial program bit.
REQ-006 SHALL have port start  input  1  transmit request, level-sampled.
REQ-007 SHALL have port reps  input  4  repetition count; patterns sent = reps+1 (1..16).
REQ-008 SHALL have port sig  output  1  serial pattern stream, registered.
REQ-009 SHALL have port busy  output  1  high while pattern bits are on sig.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL shift program register on every edge with enable=1: pat <= {pat[PAT_W-2:0], prgm}, regardless of FSM state.
REQ-012 SHALL implement FSM states IDLE, SEND, DONE.
REQ-013 SHALL accept start only in IDLE; on acceptance, snapshot pat into tx register, load bit counter PAT_W-1, load rep counter with reps, go to SEND.
REQ-014 SHALL drive sig = tx[PAT_W-1] (MSB first) from the cycle after start acceptance, one bit per cycle.
REQ-015 SHALL, in SEND, on bit counter 0 with rep counter non-zero, decrement rep counter, reload tx from the snapshot (not live pat), wrap bit counter to PAT_W-1, no idle gap.
REQ-016 SHALL, in SEND, on bit counter 0 with rep counter 0, go to DONE.
REQ-017 SHALL assert busy exactly during SEND cycles; (reps+1)*PAT_W cycles per transmission.
REQ-018 SHALL assert done for exactly one cycle (DONE state), then return to IDLE.
REQ-019 SHALL hold sig=0 in IDLE and DONE.
REQ-020 SHALL ignore start in SEND and DONE; start held high in IDLE after DONE re-triggers.
REQ-021 SHALL leave an in-flight transmission unaffected by enable/prgm/reps changes.
REQ-022 SHALL produce sequence identical to what decoder4's SIGNAL register must receive to match a decoder4 programmed with the same prgm bit sequence.

Reset
REQ-023 SHALL, on clr low, immediately force state IDLE, pat=0, tx=0, counters=0, sig=0, busy=0, done=0.
REQ-024 SHALL abort any transmission on clr low without emitting done.
REQ-025 SHALL resume normal operation on the first rising edge after clr returns high.

Structure
REQ-026 SHALL place PAT_W default and FSM state encoding in shared package encoder_pkg.
REQ-027 SHALL implement tx register and bit counter as sub-module piso4 (parallel load, shift enable, MSB out); FSM and rep counter in encoder4.

Verification
REQ-028 SHALL cover: prgm 1,0,1,1 with enable, reps=0, start pulse -> sig 1,0,1,1 on cycles 1-4, busy high cycles 1-4, done high cycle 5 only.
REQ-029 SHALL cover: pattern 1001, reps=2 -> sig 100110011001 contiguous, busy 12 cycles, single done pulse.
REQ-030 SHALL cover: start pulsed again at cycle 2 of SEND and prgm 0,0,0,0 shifted during SEND -> output unchanged, no extra transmission; next start sends 0000.
REQ-031 SHALL cover: clr low during 3rd bit -> sig/busy/done 0 same cycle asynchronously, no done; after release start sends 0000.
REQ-032 SHALL cover: loopback encoder4.sig into decoder4 sig input, both programmed 0110 -> decoder out high on the cycle after 4th bit is shifted in, low for all-0 idle stream.
REQ-033 SHALL cover: start held high continuously, reps=0 -> transmissions repeat every PAT_W+2 cycles with done between each.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and FSM encoding for the pattern encoder.
// Imported by encoder4 and piso4.
package encoder_pkg;

  localparam int PAT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/piso4.sv
// Parallel-in serial-out tx register with bit counter, MSB first.
// Ports: clk, clr (async low), load/din, shift, msb out, last (cnt==0).
module piso4
  import encoder_pkg::*;
#(
  parameter int W = PAT_W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  tx;
  logic [CW-1:0] cnt;

  // Zeros shift in, so after the final bit tx is empty and msb idles at 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tx  <= '0;
      cnt <= '0;
    end else if (load) begin
      tx  <= din;
      cnt <= CW'(W - 1);
    end else if (shift) begin
      tx <= {tx[W-2:0], 1'b0};
      if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign msb  = tx[W-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/encoder4.sv
// Programmable serial pattern transmitter with repeat count.
// Ports: clk, clr, enable/prgm (program), start, reps -> sig, busy, done.
module encoder4
  import encoder_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       prgm,
  input  logic       start,
  input  logic [3:0] reps,
  output logic       sig,
  output logic       busy,
  output logic       done
);

  state_t           state;
  state_t           state_nx;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] snap;
  logic [3:0]       rep;
  logic             accept;
  logic             reload;
  logic             load;
  logic             shift;
  logic             last;
  logic [PAT_W-1:0] din;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      pat <= '0;
    else if (enable)
      pat <= {pat[PAT_W-2:0], prgm};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_SEND;
      S_SEND: if (last && rep == 4'd0)
                state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SEND:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state == S_IDLE) && start;
  assign reload = busy && last && (rep != 4'd0);
  assign load   = accept || reload;
  assign shift  = busy && !reload;
  // Repeats come from the snapshot so live programming can't leak in.
  assign din    = accept ? pat : snap;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snap <= '0;
      rep  <= '0;
    end else if (accept) begin
      snap <= pat;
      rep  <= reps;
    end else if (reload) begin
      rep <= rep - 1'b1;
    end
  end

  piso4 #(
    .W(PAT_W)
  ) u_piso (
    .clk  (clk),
    .clr  (clr),
    .load (load),
    .shift(shift),
    .din  (din),
    .msb  (sig),
    .last (last)
  );

endmodule
